// File: rtl/xnor_match_pipe_if.sv
// rtl/xnor_match_pipe_if.sv - operand/result bundle for the XNOR match pipeline
//
// Purpose: carries the input word, its handshake, the result word, its
// handshake and the match counter between a producer/consumer and
// xnor_match_pipe.
// Ports (signals):
//   A, B, MASK      operand words and per-bit compare enable (1 = compare)
//   IN_VALID        operand word valid          (master -> slave)
//   IN_READY        pipeline can accept a word  (slave  -> master)
//   Y, EQ           XNOR word and masked equality flag
//   OUT_VALID       Y/EQ valid                  (slave  -> master)
//   OUT_READY       consumer accepts Y/EQ       (master -> slave)
//   CLR             synchronous counter clear   (master -> slave)
//   MATCH_CNT       saturating count of EQ=1 outputs
// Modports: master = stimulus/consumer side, slave = comparator side.
interface xnor_match_pipe_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) ();
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] MASK;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] Y;
    logic             EQ;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             CLR;
    logic [CNT_W-1:0] MATCH_CNT;

    modport master (
        output A, B, MASK, IN_VALID, OUT_READY, CLR,
        input  IN_READY, Y, EQ, OUT_VALID, MATCH_CNT
    );

    modport slave (
        input  A, B, MASK, IN_VALID, OUT_READY, CLR,
        output IN_READY, Y, EQ, OUT_VALID, MATCH_CNT
    );
endinterface

// File: rtl/xnor_match_pipe.sv
// rtl/xnor_match_pipe.sv - two-stage pipelined masked XNOR equality comparator
//
// Purpose: stage 1 registers A ~^ B and its masked form, stage 2 registers
// the unmasked XNOR word (Y) and the AND-reduced equality flag (EQ). Both
// stages stall under backpressure; an optional saturating counter tallies
// accepted outputs with EQ=1.
// Ports:
//   CLK   rising-edge clock
//   R     asynchronous active-low reset
//   bus   xnor_match_pipe_if.slave (operands, handshakes, Y/EQ, CLR, MATCH_CNT)
// Configuration macro: XNOR_MATCH_PIPE_CNT_EN
//   defined   - MATCH_CNT counts EQ=1 output handshakes, CLR clears it
//   undefined - no counter flops, MATCH_CNT tied to 0, CLR ignored
module xnor_match_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             R,
    xnor_match_pipe_if.slave bus
);

    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] m1_q, m1_d;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             eq_q, eq_d;
    logic             out_valid_q, out_valid_d;

    logic s2_adv;
    logic s1_adv;

    // Advance terms depend only on state and OUT_READY, so IN_READY never
    // looks at IN_VALID and a released stall refills without a bubble.
    assign s2_adv = !out_valid_q || bus.OUT_READY;
    assign s1_adv = !s1_valid_q || s2_adv;

    always_comb begin
        x1_d        = x1_q;
        m1_d        = m1_q;
        s1_valid_d  = s1_valid_q;
        y_d         = y_q;
        eq_d        = eq_q;
        out_valid_d = out_valid_q;

        if (s1_adv) begin
            x1_d       = bus.A ~^ bus.B;
            // Don't-care bits are forced to 1 so they cannot break equality.
            m1_d       = (bus.A ~^ bus.B) | ~bus.MASK;
            s1_valid_d = bus.IN_VALID;
        end

        if (s2_adv) begin
            y_d         = x1_q;
            eq_d        = &m1_q;
            out_valid_d = s1_valid_q;
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            x1_q        <= '0;
            m1_q        <= '0;
            s1_valid_q  <= 1'b0;
            y_q         <= '0;
            eq_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            x1_q        <= x1_d;
            m1_q        <= m1_d;
            s1_valid_q  <= s1_valid_d;
            y_q         <= y_d;
            eq_q        <= eq_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.IN_READY  = s1_adv;
    assign bus.Y         = y_q;
    assign bus.EQ        = eq_q;
    assign bus.OUT_VALID = out_valid_q;

`ifdef XNOR_MATCH_PIPE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_hs;

    assign out_hs = out_valid_q && bus.OUT_READY;

    // Clear wins over a same-edge counted handshake; the count sticks at
    // all-ones rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.CLR) begin
            cnt_d = '0;
        end else if (out_hs && eq_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.MATCH_CNT = cnt_q;
`else
    logic unused_clr;
    assign unused_clr    = bus.CLR;
    assign bus.MATCH_CNT = '0;
`endif

endmodule

// File: tb/tb_xnor_match_pipe.sv
// tb/tb_xnor_match_pipe.sv - scoreboard bench for xnor_match_pipe
module tb_xnor_match_pipe;

    localparam int WIDTH = 32;
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
`ifdef XNOR_MATCH_PIPE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             eq;
        int               acc;
        bit               lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_err;
    exp_t sb[$];
    logic [CNT_W-1:0] exp_cnt;

    xnor_match_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    xnor_match_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .CLK (clk),
        .R   (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Offer one word; pushes its expected result when the handshake fires.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] m, input bit lat);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.A        = a;
        bus.B        = b;
        bus.MASK     = m;
        bus.IN_VALID = 1'b1;
        #1;
        n = 0;
        while (!bus.IN_READY && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("send_accept", bus.IN_READY, 1'b1);
        if (bus.IN_READY) begin
            e.y   = ~(a ^ b);
            e.eq  = (((~(a ^ b)) | ~m) == {WIDTH{1'b1}});
            e.acc = cyc;
            e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain", sb.size(), 0);
    endtask

    // Output monitor and counter model, sampled mid low phase.
    initial begin
        bit               prev_stall;
        logic [WIDTH-1:0] prev_y;
        logic             prev_eq;
        bit               hs;
        logic             eq_exp;
        exp_t             e;
        prev_stall = 1'b0;
        prev_y     = '0;
        prev_eq    = 1'b0;
        exp_cnt    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                exp_cnt    = '0;
                prev_stall = 1'b0;
            end else begin
                chk("match_cnt", bus.MATCH_CNT, exp_cnt);
                if (prev_stall) begin
                    chk("stall_valid", bus.OUT_VALID, 1'b1);
                    chk("stall_y", bus.Y, prev_y);
                    chk("stall_eq", bus.EQ, prev_eq);
                end
                hs     = bus.OUT_VALID && bus.OUT_READY;
                eq_exp = 1'b0;
                if (hs) begin
                    chk("sb_nonempty", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("y", bus.Y, e.y);
                        chk("eq", bus.EQ, e.eq);
                        if (e.lat) chk("latency", cyc - e.acc, 2);
                        eq_exp = e.eq;
                    end
                end
                if (CNT_ON) begin
                    if (bus.CLR) exp_cnt = '0;
                    else if (hs && eq_exp && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
                end
                prev_stall = bus.OUT_VALID && !bus.OUT_READY;
                prev_y     = bus.Y;
                prev_eq    = bus.EQ;
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] ra, rb, rm;
        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.MASK      = '0;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        bus.CLR       = 1'b0;
        #1;
        chk("rst_out_valid", bus.OUT_VALID, 1'b0);
        chk("rst_y", bus.Y, 0);
        chk("rst_eq", bus.EQ, 1'b0);
        chk("rst_cnt", bus.MATCH_CNT, 0);
        chk("rst_in_ready", bus.IN_READY, 1'b1);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;

        // Streaming equality, back to back.
        send(32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1);
        send(32'hDEADBEEF, 32'hDEADBEEE, 32'hFFFFFFFF, 1'b1);
        drain();
        chk("stream_cnt", bus.MATCH_CNT, CNT_ON ? 1 : 0);

        // Masking.
        send(32'h0000FFFF, 32'h1234FFFF, 32'h0000FFFF, 1'b1);
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? ra : (ra ^ (32'h1 << $urandom_range(31, 0)));
            rm = (i < 3) ? 32'hFFFFFFFF : $urandom;
            send(ra, rb, rm, 1'b1);
        end
        drain();

        // Backpressure: two words fill the pipe, the third waits.
        @(negedge clk);
        bus.OUT_READY = 1'b0;
        send(32'h11111111, 32'h11111111, 32'hFFFFFFFF, 1'b0);
        send(32'h22222222, 32'h22222223, 32'hFFFFFFFF, 1'b0);
        fork
            send(32'h33333333, 32'h33333333, 32'hFFFFFFFF, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    chk("bp_in_ready", bus.IN_READY, 1'b0);
                end
                @(negedge clk);
                bus.OUT_READY = 1'b1;
                #1;
                chk("bp_release", bus.IN_READY, 1'b1);
            end
        join
        drain();

        // Saturation after a clear.
        @(negedge clk);
        bus.CLR = 1'b1;
        @(negedge clk);
        bus.CLR = 1'b0;
        for (int i = 0; i < 5; i++) send(32'hA5A5A5A5 + i, 32'hA5A5A5A5 + i, 32'hFFFFFFFF, 1'b1);
        drain();
        chk("sat_cnt", bus.MATCH_CNT, CNT_ON ? 3 : 0);

        // Clear beats a simultaneous counted handshake.
        @(negedge clk);
        bus.CLR = 1'b1;
        @(negedge clk);
        bus.CLR = 1'b0;
        send(32'h0F0F0F0F, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b1);
        drain();
        chk("one_cnt", bus.MATCH_CNT, CNT_ON ? 1 : 0);
        @(negedge clk);
        bus.CLR = 1'b1;
        send(32'h0F0F0F0F, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b1);
        drain();
        @(negedge clk);
        bus.CLR = 1'b0;
        #1;
        chk("clr_prio_cnt", bus.MATCH_CNT, 0);

        // Async reset with both stages full and stalled.
        send(32'h12345678, 32'h12345678, 32'hFFFFFFFF, 1'b1);
        drain();
        @(negedge clk);
        bus.OUT_READY = 1'b0;
        send(32'hCAFEF00D, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0);
        send(32'hBEEFCAFE, 32'hBEEFCAFE, 32'hFFFFFFFF, 1'b0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.OUT_VALID, 1'b0);
        chk("arst_y", bus.Y, 0);
        chk("arst_eq", bus.EQ, 1'b0);
        chk("arst_cnt", bus.MATCH_CNT, 0);
        chk("arst_in_ready", bus.IN_READY, 1'b1);
        sb.delete();
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        bus.OUT_READY = 1'b1;
        send(32'h00C0FFEE, 32'h00C0FFEF, 32'hFFFFFFFE, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/xnor_match_pipe.md
# xnor_match_pipe

- Parametrised, pipelined bitwise XNOR equality comparator.
- Registers the masked per-bit XNOR of two operand words and reduces it to a single equality flag.
- Two-stage valid/ready pipeline with full backpressure, plus an optional saturating match counter.
- Sits beside the XNOR2 cell family as the synthesisable comparator used by address/tag match logic in student SoC datapaths.

## Interface

Parameters:
- WIDTH, 32: operand width in bits (≥1).
- CNT_W, 16: match counter width in bits (≥1).

Ports:
- CLK  input  1  rising-edge clock.
- R  input  1  reset, asynchronous, active-low.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- MASK  input  WIDTH  bit compare enable; 1 = compare, 0 = don't-care.
- IN_VALID  input  1  operand word valid.
- IN_READY  output  1  pipeline can accept a word this cycle.
- Y  output  WIDTH  registered bitwise XNOR of A and B, unmasked.
- EQ  output  1  every masked bit of A equals the corresponding bit of B.
- OUT_VALID  output  1  Y/EQ valid.
- OUT_READY  input  1  consumer accepts Y/EQ.
- CLR  input  1  synchronous clear of MATCH_CNT.
- MATCH_CNT  output  CNT_W  number of accepted outputs with EQ=1 (saturating).

## Operation

- Input handshake fires when IN_VALID && IN_READY. Output handshake fires when OUT_VALID && OUT_READY.
- Stage 1 (s1) captures:
  - x1 = A ~^ B
  - m1 = x1 | ~MASK
  - s1_valid
- Stage 2 (s2) captures:
  - Y = x1
  - EQ = &m1 (AND reduction over all WIDTH bits)
  - OUT_VALID = s1_valid
- Stall rules:
  - s2_adv = !OUT_VALID || OUT_READY
  - s1_adv = !s1_valid || s2_adv
  - IN_READY = s1_adv (combinational from state and OUT_READY; no path from IN_VALID).
- On s1_adv, s1 loads the input word and s1_valid <= IN_VALID. Otherwise s1 holds.
- On s2_adv, s2 loads from s1. Otherwise Y, EQ and OUT_VALID hold stable.
- Y and EQ must not change while OUT_VALID=1 && OUT_READY=0.
- MASK = 0 gives EQ=1 regardless of A and B. Y always reflects all bits, ignoring MASK.
- Counter:
  - MATCH_CNT increments by 1 on an output handshake with EQ=1.
  - Saturates at 2^CNT_W−1 and does not wrap.
  - CLR=1 sets MATCH_CNT to 0 next edge. CLR has priority over a simultaneous counted handshake: the result is 0, not 1.
- Reset (R=0, asynchronous, any time including mid-stall):
  - s1_valid=0, OUT_VALID=0, Y=0, EQ=0, MATCH_CNT=0.
  - In-flight words are discarded.
  - IN_READY=1 while in reset and after release.
  - After R deasserts, the first capturing edge is the next rising CLK.

## Timing

- Latency: an accepted word appears on OUT_VALID/Y/EQ exactly 2 rising edges after its input handshake edge, when there is no backpressure.
- Throughput: 1 word/cycle while OUT_READY=1.
- Capacity: 2 words (s1 + s2). With OUT_READY held 0, IN_READY drops to 0 once both stages are valid.
- Release: when OUT_READY returns to 1, IN_READY=1 in the same cycle (combinational), so no bubble is inserted.
- MATCH_CNT updates on the edge at which the output handshake occurs and is visible the following cycle.
- All outputs except IN_READY are registered.

## Configuration

- Macro XNOR_MATCH_PIPE_CNT_EN.
- Defined: the counter and CLR behave as above.
- Undefined:
  - No counter flops are built.
  - MATCH_CNT is tied to 0.
  - CLR is ignored.
  - Pipeline behaviour, latency and the port list are unchanged.

## Test plan

- Equality, streaming:
  - Stimulus: WIDTH=32, MASK=FFFFFFFF, OUT_READY=1. Send A=B=DEADBEEF, then A=DEADBEEF/B=DEADBEEE.
  - Required: EQ=1 with Y=FFFFFFFF at cycle+2, then EQ=0 with Y=FFFFFFFE the next cycle; MATCH_CNT=1.
- Mask:
  - Stimulus: A=0000FFFF, B=1234FFFF, MASK=0000FFFF.
  - Required: EQ=1, Y=EDCBFFFF.
  - Stimulus: MASK=0 with any operands.
  - Required: EQ=1.
- Backpressure:
  - Stimulus: OUT_READY=0 while 3 words are offered back-to-back.
  - Required: IN_READY=0 after 2 are accepted; Y/EQ stable for 5 stalled cycles. Raising OUT_READY delivers words 1, 2, 3 in order with no loss or duplication.
- Saturation and clear:
  - Stimulus: CNT_W=2, 5 matching words.
  - Required: MATCH_CNT sequence 1, 2, 3, 3, 3.
  - Stimulus: CLR asserted on the same edge as a matching handshake.
  - Required: MATCH_CNT=0.
- Async reset:
  - Stimulus: assert R=0 mid-cycle with both stages full and stalled.
  - Required: OUT_VALID=0, EQ=0, Y=0 and MATCH_CNT=0 immediately, without waiting for CLK. IN_READY=1; the first post-reset word emerges 2 cycles after acceptance.
- Macro off:
  - Stimulus: build without XNOR_MATCH_PIPE_CNT_EN and run the streaming test.
  - Required: identical Y/EQ/handshakes; MATCH_CNT stays 0 throughout.
